// File: rtl/axis_fifo_frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// axis_fifo_frame_sched_pkg
//
// Purpose: shared definitions for the frame scheduler and its round-robin
// encoder.
//   - sched_state_e : scheduler FSM encoding (IDLE, XFER)
//   - clog2         : ceiling log2 for width derivation at elaboration time
//   - idx_width     : width of a source index (at least 1 bit)
//   - occ_width     : width of an occupancy counter that must hold 0..depth
// -----------------------------------------------------------------------------
package axis_fifo_frame_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } sched_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Counter must represent the full value "depth", hence depth+1 states.
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axis_fifo_frame_sched_rr.sv
// -----------------------------------------------------------------------------
// axis_fifo_frame_sched_rr
//
// Purpose: combinational round-robin priority encoder. Picks the first
// asserted request strictly after the pointer position, wrapping around, so
// the pointer holding the last winner gives that winner lowest priority.
//
// Ports:
//   req_i       in  N   request vector
//   ptr_i       in  IW  index of the previous winner
//   grant_oh_o  out N   one-hot of the selected request
//   grant_idx_o out IW  index of the selected request
//   valid_o     out 1   at least one request was selected
// -----------------------------------------------------------------------------
module axis_fifo_frame_sched_rr
    import axis_fifo_frame_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          valid_o
);

    always_comb begin
        int c;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        c           = 0;
        // Scan offsets 1..N from the pointer; offset N lands on the pointer
        // itself, so a lone requester that just won can still win again.
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[c]) begin
                valid_o       = 1'b1;
                grant_oh_o[c] = 1'b1;
                grant_idx_o   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/axis_fifo_frame_sched.sv
// -----------------------------------------------------------------------------
// axis_fifo_frame_sched
//
// Purpose: frame-granular round-robin scheduler sharing one FIFO write port
// between S_COUNT AXI-Stream sources. A source is granted only when the FIFO
// has room for MAX_FRAME_WORDS words; the whole frame then passes through a
// combinational mux, tagged with the source index on m_axis_tid. FIFO
// occupancy is tracked locally from accepted writes and the fifo_pop strobe.
//
// Handshake: a word moves on any cycle where valid and ready are both high on
// the same interface; valid never depends on ready of the same interface.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_axis_*                 S_COUNT packed source ports (slice i = source i)
//   m_axis_*                 single stream into the FIFO write side
//   fifo_pop                 one word left the FIFO this cycle
//   status_grant             index of the current or last grant
//   status_busy              high while a frame is being transferred (XFER)
//   status_occupancy         tracked FIFO word count
//   status_oversize          one-cycle pulse after a word beyond
//                            MAX_FRAME_WORDS was accepted
// -----------------------------------------------------------------------------
module axis_fifo_frame_sched
    import axis_fifo_frame_sched_pkg::*;
#(
    parameter int S_COUNT         = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int DEST_WIDTH      = 8,
    parameter int USER_WIDTH      = 1,
    parameter int ID_WIDTH        = 8,
    parameter int FIFO_DEPTH      = 32,
    parameter int MAX_FRAME_WORDS = 8,
    localparam int IW             = idx_width(S_COUNT),
    localparam int OW             = occ_width(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,

    input  logic                          fifo_pop,

    output logic [IW-1:0]                 status_grant,
    output logic                          status_busy,
    output logic [OW-1:0]                 status_occupancy,
    output logic                          status_oversize
);

    // Word counter only needs to reach MAX_FRAME_WORDS; it saturates there.
    localparam int CW = clog2(MAX_FRAME_WORDS + 1);

    sched_state_e         state_q;
    logic [IW-1:0]        grant_q;
    logic [S_COUNT-1:0]   grant_oh_q;
    logic [IW-1:0]        ptr_q;
    logic [CW-1:0]        wcnt_q;
    logic                 oversize_q;
    logic [OW-1:0]        occ_q;
    logic [OW-1:0]        occ_d;

    logic                 busy;
    logic                 not_full;
    logic                 room;
    logic                 wr_hs;

    logic [S_COUNT-1:0]   arb_oh;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;

    assign busy     = (state_q == ST_XFER);
    assign not_full = (occ_q < OW'(FIFO_DEPTH));
    // Free space >= MAX_FRAME_WORDS, written without a subtraction on occ_q.
    assign room     = (occ_q <= OW'(FIFO_DEPTH - MAX_FRAME_WORDS));

    axis_fifo_frame_sched_rr #(
        .N  (S_COUNT),
        .IW (IW)
    ) u_rr (
        .req_i       (s_axis_tvalid),
        .ptr_i       (ptr_q),
        .grant_oh_o  (arb_oh),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    // Data path: plain mux from the granted port.
    always_comb begin
        int g;
        g             = int'(grant_q);
        m_axis_tdata  = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tdest  = s_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH];
        m_axis_tuser  = s_axis_tuser[g*USER_WIDTH +: USER_WIDTH];
        m_axis_tlast  = s_axis_tlast[g];
        m_axis_tvalid = busy && s_axis_tvalid[g] && not_full;
        m_axis_tid    = '0;
        m_axis_tid[IW-1:0] = grant_q;
    end

    // Only the granted source ever sees ready; the one-hot register avoids a
    // second index decode here.
    assign s_axis_tready = (busy && m_axis_tready && not_full) ? grant_oh_q : '0;

    assign wr_hs = m_axis_tvalid && m_axis_tready;

    // Write and pop in the same cycle cancel; both ends saturate.
    always_comb begin
        occ_d = occ_q;
        if (wr_hs && !fifo_pop) begin
            if (occ_q != OW'(FIFO_DEPTH)) begin
                occ_d = occ_q + OW'(1);
            end
        end else if (!wr_hs && fifo_pop) begin
            if (occ_q != '0) begin
                occ_d = occ_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Scheduler FSM with its registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            ptr_q      <= IW'(S_COUNT - 1);
            wcnt_q     <= '0;
            oversize_q <= 1'b0;
        end else begin
            oversize_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid && room) begin
                        grant_q    <= arb_idx;
                        grant_oh_q <= arb_oh;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (wr_hs) begin
                        // Oversize frames are flagged but never cut short.
                        oversize_q <= (wcnt_q >= CW'(MAX_FRAME_WORDS));
                        if (m_axis_tlast) begin
                            ptr_q   <= grant_q;
                            wcnt_q  <= '0;
                            state_q <= ST_IDLE;
                        end else if (wcnt_q < CW'(MAX_FRAME_WORDS)) begin
                            wcnt_q <= wcnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign status_grant     = grant_q;
    assign status_busy      = busy;
    assign status_occupancy = occ_q;
    assign status_oversize  = oversize_q;

endmodule

// File: tb/tb_axis_fifo_frame_sched.sv
module tb_axis_fifo_frame_sched;

    localparam int S     = 4;
    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int DSTW  = 8;
    localparam int UW    = 1;
    localparam int IDW   = 8;
    localparam int DEPTH = 32;
    localparam int MAXW  = 8;
    localparam int GW    = 2;
    localparam int OCCW  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S*DW-1:0]   s_tdata;
    logic [S*KW-1:0]   s_tkeep;
    logic [S-1:0]      s_tvalid;
    logic [S-1:0]      s_tready;
    logic [S-1:0]      s_tlast;
    logic [S*DSTW-1:0] s_tdest;
    logic [S*UW-1:0]   s_tuser;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [IDW-1:0]    m_tid;
    logic [DSTW-1:0]   m_tdest;
    logic [UW-1:0]     m_tuser;
    logic              fifo_pop;
    logic [GW-1:0]     st_grant;
    logic              st_busy;
    logic [OCCW-1:0]   st_occ;
    logic              st_ovs;

    axis_fifo_frame_sched #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(DSTW),
        .USER_WIDTH(UW), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH), .MAX_FRAME_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
        .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .fifo_pop(fifo_pop),
        .status_grant(st_grant), .status_busy(st_busy),
        .status_occupancy(st_occ), .status_oversize(st_ovs)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- source driver state ----------------
    int frames_todo[S];
    int len_fixed[S];
    int cur_len[S];
    int cur_idx[S];
    int frame_no[S];
    int hs_cnt[S];
    int valid_pct = 100;
    int ready_pct = 100;
    int pop_pct   = 0;
    int pop_mode  = 0;   // 0 none, 1 random at pop_pct, 2 pop exactly when a word is written

    logic [DW-1:0]   src_data [S];
    logic [KW-1:0]   src_keep [S];
    logic [DSTW-1:0] src_dest [S];
    logic [UW-1:0]   src_user [S];
    logic            src_last [S];

    // ---------------- behavioural model ----------------
    bit m_busy;
    int m_grant;
    int m_ptr;
    int m_words;
    int m_occ;
    bit m_ovs;

    bit         last_tvalid;
    logic [S-1:0] last_ready;
    bit         prev_busy;
    int         grant_log[$];
    int         ovs_cnt;

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_ptr = S - 1; m_words = 0; m_occ = 0; m_ovs = 0;
    endtask

    task automatic clear_sources();
        for (int s = 0; s < S; s++) begin
            frames_todo[s] = 0; len_fixed[s] = 0; cur_len[s] = 0;
            cur_idx[s] = 0; hs_cnt[s] = 0;
        end
    endtask

    task automatic drive_inputs();
        bit v;
        for (int s = 0; s < S; s++) begin
            v = 1'b0;
            if (frames_todo[s] > 0) begin
                if (cur_len[s] == 0)
                    cur_len[s] = (len_fixed[s] > 0) ? len_fixed[s] : int'($urandom_range(1, 10));
                v = ($urandom_range(0, 99) < valid_pct);
            end
            src_data[s] = {8'(s), 24'(frame_no[s]), 32'(cur_idx[s])};
            src_keep[s] = 8'(s * 16 + cur_idx[s]);
            src_dest[s] = 8'(frame_no[s] * 3 + cur_idx[s]);
            src_user[s] = 1'(cur_idx[s]);
            src_last[s] = (cur_idx[s] == cur_len[s] - 1);
            s_tvalid[s] = v;
            s_tlast[s]  = src_last[s];
            s_tdata[s*DW +: DW]     = src_data[s];
            s_tkeep[s*KW +: KW]     = src_keep[s];
            s_tdest[s*DSTW +: DSTW] = src_dest[s];
            s_tuser[s*UW +: UW]     = src_user[s];
        end
        m_tready = ($urandom_range(0, 99) < ready_pct);
        fifo_pop = (pop_mode == 1) ? ($urandom_range(0, 99) < pop_pct) : 1'b0;
    endtask

    // Compare DUT against the model for this cycle, then advance model + sources.
    task automatic check_and_advance();
        bit nf, exp_tv, hs, room;
        logic [S-1:0] exp_rdy;
        int pick, c;
        nf     = (m_occ < DEPTH);
        room   = ((DEPTH - m_occ) >= MAXW);
        exp_tv = m_busy && s_tvalid[m_grant] && nf;
        hs     = exp_tv && m_tready;
        if (pop_mode == 2) fifo_pop = hs;
        exp_rdy = '0;
        if (m_busy && m_tready && nf) exp_rdy[m_grant] = 1'b1;

        chk("m_tvalid", m_tvalid, exp_tv);
        chk("s_tready", s_tready, exp_rdy);
        chk("status_busy", st_busy, m_busy);
        chk("status_grant", st_grant, m_grant);
        chk("status_occupancy", st_occ, m_occ);
        chk("status_oversize", st_ovs, m_ovs);
        if (exp_tv) begin
            chk("m_tdata", m_tdata, src_data[m_grant]);
            chk("m_tkeep", m_tkeep, src_keep[m_grant]);
            chk("m_tlast", m_tlast, src_last[m_grant]);
            chk("m_tid", m_tid, m_grant);
            chk("m_tdest", m_tdest, src_dest[m_grant]);
            chk("m_tuser", m_tuser, src_user[m_grant]);
        end
        last_tvalid = m_tvalid;
        last_ready  = s_tready;
        prev_busy   = st_busy;
        if (st_ovs) ovs_cnt++;

        for (int s = 0; s < S; s++) begin
            if (s_tvalid[s] && exp_rdy[s]) begin
                hs_cnt[s]++;
                if (cur_idx[s] == cur_len[s] - 1) begin
                    frames_todo[s]--; frame_no[s]++; cur_idx[s] = 0; cur_len[s] = 0;
                end else begin
                    cur_idx[s]++;
                end
            end
        end

        if (hs && !fifo_pop && m_occ < DEPTH) m_occ++;
        else if (fifo_pop && !hs && m_occ > 0) m_occ--;

        m_ovs = 0;
        if (!m_busy) begin
            if (room) begin
                pick = -1;
                for (int k = 1; k <= S; k++) begin
                    c = (m_ptr + k) % S;
                    if (pick < 0 && s_tvalid[c]) pick = c;
                end
                if (pick >= 0) begin m_busy = 1; m_grant = pick; end
            end
        end else if (hs) begin
            m_ovs = (m_words >= MAXW);
            m_words++;
            if (src_last[m_grant]) begin m_busy = 0; m_ptr = m_grant; m_words = 0; end
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_inputs();
        #1;
        check_and_advance();
        @(posedge clk);
        #1;
        if (st_busy && !prev_busy) grant_log.push_back(int'(st_grant));
    endtask

    function automatic bit any_todo();
        for (int s = 0; s < S; s++) if (frames_todo[s] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while (any_todo() && n < budget) begin step(); n++; end
        chk({name, "_timeout"}, (n < budget), 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources(); model_reset();
        s_tvalid = '0; m_tready = 1'b0; fifo_pop = 1'b0; prev_busy = 0;
        pop_mode = 0; valid_pct = 100; ready_pct = 100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < S; s++) frame_no[s] = 0;
        s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tdest = '0; s_tuser = '0;
        ovs_cnt = 0;
        do_reset();

        // Reset values
        chk("rst_occ", st_occ, 0);
        chk("rst_busy", st_busy, 0);
        chk("rst_grant", st_grant, 0);
        chk("rst_ovs", st_ovs, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);

        // Single 4-word frame from source 0
        len_fixed[0] = 4; frames_todo[0] = 1;
        step();
        chk("t1_arb_busy", st_busy, 1);
        chk("t1_arb_no_data", last_tvalid, 0);
        run_until_done("t1", 20);
        chk("t1_words", hs_cnt[0], 4);
        chk("t1_occ", st_occ, 4);
        chk("t1_idle", st_busy, 0);

        // Round-robin order across four 2-word frames
        do_reset();
        grant_log.delete();
        for (int s = 0; s < S; s++) begin len_fixed[s] = 2; frames_todo[s] = 1; end
        run_until_done("t2", 60);
        step();
        chk("t2_ngrants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < grant_log.size()) chk("t2_order", grant_log[i], i);
        chk("t2_occ", st_occ, 8);

        // Room gating: occupancy 25 blocks a grant until one pop
        do_reset();
        len_fixed[1] = 8; frames_todo[1] = 3;
        run_until_done("t3a", 60);
        len_fixed[1] = 1; frames_todo[1] = 1;
        run_until_done("t3b", 10);
        step();
        chk("t3_occ25", st_occ, 25);
        len_fixed[1] = 8; frames_todo[1] = 1;
        repeat (5) step();
        chk("t3_no_grant", st_busy, 0);
        pop_mode = 1; pop_pct = 100;
        step();
        pop_mode = 0;
        chk("t3_occ24", st_occ, 24);
        chk("t3_still_idle", st_busy, 0);
        step();
        chk("t3_granted", st_busy, 1);
        chk("t3_grant_idx", st_grant, 1);
        run_until_done("t3c", 30);

        // Simultaneous write + pop, and pop at zero
        do_reset();
        len_fixed[0] = 8; frames_todo[0] = 1;
        run_until_done("t4a", 20);
        len_fixed[0] = 2; frames_todo[0] = 1;
        run_until_done("t4b", 10);
        step();
        chk("t4_occ10", st_occ, 10);
        pop_mode = 2;
        len_fixed[0] = 3; frames_todo[0] = 1;
        run_until_done("t4c", 10);
        step();
        chk("t4_occ_hold", st_occ, 10);
        do_reset();
        pop_mode = 1; pop_pct = 100;
        repeat (3) step();
        chk("t4_occ_zero", st_occ, 0);

        // Oversize frame and FIFO-full stall
        do_reset();
        ovs_cnt = 0;
        len_fixed[3] = 10; frames_todo[3] = 1;
        run_until_done("t5a", 30);
        step();
        chk("t5_ovs_pulses", ovs_cnt, 2);
        chk("t5_words", hs_cnt[3], 10);
        chk("t5_occ10", st_occ, 10);
        len_fixed[3] = 8; frames_todo[3] = 1;
        run_until_done("t5b", 20);
        len_fixed[3] = 6; frames_todo[3] = 1;
        run_until_done("t5c", 20);
        len_fixed[3] = 12; frames_todo[3] = 1;
        repeat (15) step();
        chk("t5_full", st_occ, 32);
        chk("t5_stall_busy", st_busy, 1);
        chk("t5_stall_tvalid", last_tvalid, 0);
        chk("t5_stall_tready", last_ready, 0);
        pop_mode = 1; pop_pct = 100;
        run_until_done("t5d", 30);

        // Reset during word 3 of a frame from source 2
        do_reset();
        len_fixed[2] = 6; frames_todo[2] = 1;
        begin
            int n;
            n = 0;
            while (hs_cnt[2] < 2 && n < 20) begin step(); n++; end
            chk("t6_reach_timeout", (n < 20), 1'b1);
        end
        @(negedge clk);
        drive_inputs();
        #1;
        chk("t6_word3_valid", m_tvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", m_tvalid, 0);
        chk("t6_rst_tready", s_tready, 0);
        chk("t6_rst_occ", st_occ, 0);
        chk("t6_rst_busy", st_busy, 0);
        clear_sources(); model_reset(); prev_busy = 0;
        s_tvalid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        len_fixed[0] = 2; frames_todo[0] = 1;
        len_fixed[2] = 2; frames_todo[2] = 1;
        run_until_done("t6", 30);
        chk("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Randomized traffic against the model
        do_reset();
        valid_pct = 70; ready_pct = 80; pop_mode = 1; pop_pct = 45;
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < S; s++) if (frames_todo[s] == 0) frames_todo[s] = 1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_fifo_frame_sched.md
Name: axis_fifo_frame_sched

Overview:
Frame-granular round-robin scheduler that shares one axis_fifo write port (64-bit default) between S_COUNT AXI-Stream sources. It grants a source only when the downstream FIFO has room for a worst-case frame, and tags each frame with its source index on tid. It tracks FIFO occupancy from the accepted writes and from the pop strobe returned by the FIFO read side.

Parameters:
S_COUNT, 4, number of source ports (2..16)
DATA_WIDTH, 64, tdata width per port
KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port
DEST_WIDTH, 8, tdest width per port
USER_WIDTH, 1, tuser width per port
ID_WIDTH, 8, m_axis_tid width; must be >= clog2(S_COUNT)
FIFO_DEPTH, 32, downstream FIFO depth in words
MAX_FRAME_WORDS, 8, words reserved per grant; must be <= FIFO_DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data, port i at slice i
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  source byte enables
s_axis_tvalid  in  S_COUNT  source valid
s_axis_tready  out  S_COUNT  source ready
s_axis_tlast  in  S_COUNT  source end of frame
s_axis_tdest  in  S_COUNT*DEST_WIDTH  source dest
s_axis_tuser  in  S_COUNT*USER_WIDTH  source user
m_axis_tdata  out  DATA_WIDTH  to FIFO s_axis_tdata
m_axis_tkeep  out  KEEP_WIDTH  to FIFO
m_axis_tvalid  out  1  to FIFO
m_axis_tready  in  1  from FIFO s_axis_tready
m_axis_tlast  out  1  to FIFO
m_axis_tid  out  ID_WIDTH  granted source index, zero-extended
m_axis_tdest  out  DEST_WIDTH  to FIFO
m_axis_tuser  out  USER_WIDTH  to FIFO
fifo_pop  in  1  one word left the FIFO this cycle (FIFO m_axis tvalid&&tready)
status_grant  out  clog2(S_COUNT)  index of current or last grant
status_busy  out  1  state is XFER
status_occupancy  out  clog2(FIFO_DEPTH+1)  tracked FIFO word count
status_oversize  out  1  one-cycle pulse: word accepted beyond MAX_FRAME_WORDS

Behaviour:
- Reset (async, rst=1): state IDLE, occupancy 0, rr pointer S_COUNT-1 (source 0 wins first), frame word count 0, status_grant 0, status_oversize 0; all s_axis_tready 0, m_axis_tvalid 0.
- States: IDLE, XFER.
- IDLE: if any s_axis_tvalid and (FIFO_DEPTH - occupancy) >= MAX_FRAME_WORDS -> select first requester strictly after rr pointer (wrapping), latch the index, go to XFER next cycle. Otherwise stay in IDLE. Arbitration latency is 1 cycle; no data moves in IDLE.
- XFER: combinational mux from the granted port. m_axis_tvalid = s_tvalid[g] && (occupancy < FIFO_DEPTH). s_axis_tready[g] = m_axis_tready && (occupancy < FIFO_DEPTH). All other readies are 0. m_axis_tid = g.
- Write handshake (m_axis_tvalid && m_axis_tready): frame word count +1. When m_axis_tlast is set: rr pointer <= g, word count <= 0, return to IDLE. Back-to-back frames therefore have one idle cycle between them.
- Occupancy: +1 on write handshake only; -1 on fifo_pop only; unchanged when both occur in the same cycle. Saturates at 0 and FIFO_DEPTH and never wraps; a fifo_pop at 0 is ignored.
- Oversize: a handshake while word count >= MAX_FRAME_WORDS pulses status_oversize. The frame keeps flowing, gated only by occupancy < FIFO_DEPTH, and is never truncated.
- A source dropping tvalid mid-frame holds the grant; there is no timeout.
- Reset asserted mid-frame: immediate IDLE. The upstream frame is abandoned, and the FIFO is expected to be reset together with this block.

Decomposition:
- Shared package: state encoding (IDLE/XFER), clog2 helper, and the width-derivation constants for the index and occupancy widths.
- One sub-module: axis_fifo_frame_sched_rr, a combinational round-robin priority encoder (request vector, pointer -> one-hot and index, valid). It is reusable by other arb muxes.
- Occupancy counter and FSM stay in the top.

Test Plan:
- Single source 0 sends a 4-word frame, FIFO always ready -> 1 IDLE cycle, then 4 words with tid=0, tlast on word 4; occupancy reaches 4; with no pops it returns to IDLE.
- Sources 0–3 each hold a 2-word frame, no pops, depth 32 -> grants in order 0,1,2,3 with tid matching; final occupancy 8.
- Occupancy preloaded to 25 (free 7 < 8), source 1 valid -> no grant. One fifo_pop (free 8) -> grant issued next cycle.
- Simultaneous write handshake and fifo_pop at occupancy 10 -> occupancy stays 10; pop alone at 0 -> stays 0.
- 10-word frame with MAX_FRAME_WORDS=8 -> status_oversize pulses on words 9 and 10; all 10 words delivered; FIFO fills to 32 -> m_axis_tvalid and s_axis_tready drop until a pop.
- rst asserted during word 3 of a frame from source 2 -> outputs 0 within the same cycle, occupancy 0; next arbitration grants source 0 first.
